rename_map_ckpt: RTL and testbench

//  WIDTH-lane register rename unit: speculative map, committed map and NUM_CKPT branch checkpoints.

---
 rtl/rename_map_ckpt.sv | 177 +++++++++++++++++
 tb/tb_rename_map_ckpt.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_ckpt.sv
// Register rename unit: speculative/committed maps with a circular queue of branch checkpoints.
// Renames up to WIDTH lanes per cycle with intra-group bypass; recover/flush restore the map in one cycle.
module rename_map_ckpt #(
    parameter int WIDTH     = 4,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int NUM_CKPT  = 4,
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(NUM_CKPT),
    localparam int NW = $clog2(WIDTH + 1),
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH-1:0][4:0]      in_rs1,
    input  logic [WIDTH-1:0][4:0]      in_rs2,
    input  logic [WIDTH-1:0][4:0]      in_rd,
    input  logic [WIDTH-1:0]           in_rd_valid,
    input  logic [WIDTH-1:0]           in_is_branch,
    output logic                       in_ready,
    input  logic [WIDTH-1:0][PW-1:0]   fl_phys,
    input  logic [PW:0]                fl_count,
    output logic [NW-1:0]              fl_pop,
    output logic [WIDTH-1:0]           out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0][PW-1:0]   out_prs1,
    output logic [WIDTH-1:0][PW-1:0]   out_prs2,
    output logic [WIDTH-1:0][PW-1:0]   out_prd,
    output logic [WIDTH-1:0][PW-1:0]   out_old_prd,
    output logic [WIDTH-1:0][CW-1:0]   out_ckpt_id,
    input  logic [WIDTH-1:0]           commit_en,
    input  logic [WIDTH-1:0][4:0]      commit_arch_rd,
    input  logic [WIDTH-1:0][PW-1:0]   commit_phys_rd,
    input  logic                       ckpt_release,
    input  logic                       recover_en,
    input  logic [CW-1:0]              recover_id,
    input  logic                       flush_en
);

    typedef logic [ARCH_REGS-1:0][PW-1:0] map_t;

    map_t                     spec_map, comm_map, spec_next, comm_next, snap;
    map_t                     ckpt_mem [NUM_CKPT];
    logic [CW-1:0]            head, tail, head_rel;
    logic                     full, empty, full_eff, has_br, accept;
    logic [WIDTH-1:0]         ren;
    logic [NW-1:0]            n_ren;
    logic [IW-1:0]            k;
    logic [WIDTH-1:0][PW-1:0] lane_prd, prs1, prs2, old_prd;
    logic [WIDTH-1:0][CW-1:0] lane_ckpt;

    always_comb begin
        ren       = '0;
        n_ren     = '0;
        k         = '0;
        lane_prd  = '0;
        prs1      = '0;
        prs2      = '0;
        old_prd   = '0;
        lane_ckpt = '0;
        spec_next = spec_map;
        snap      = spec_map;
        has_br    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ren[i]      = in_valid[i] && in_rd_valid[i] && (in_rd[i] != 5'd0);
            lane_prd[i] = ren[i] ? fl_phys[k] : '0;
            if (ren[i]) begin
                k     = k + IW'(1);
                n_ren = n_ren + NW'(1);
            end
        end
        // Later lanes overwrite earlier ones, so the youngest older writer wins.
        for (int j = 0; j < WIDTH; j++) begin
            prs1[j]    = spec_map[in_rs1[j]];
            prs2[j]    = spec_map[in_rs2[j]];
            old_prd[j] = spec_map[in_rd[j]];
            for (int i = 0; i < WIDTH; i++) begin
                if (i < j && ren[i]) begin
                    if (in_rd[i] == in_rs1[j]) prs1[j]    = lane_prd[i];
                    if (in_rd[i] == in_rs2[j]) prs2[j]    = lane_prd[i];
                    if (in_rd[i] == in_rd[j])  old_prd[j] = lane_prd[i];
                end
            end
            if (in_rs1[j] == 5'd0) prs1[j] = '0;
            if (in_rs2[j] == 5'd0) prs2[j] = '0;
            if (!ren[j]) old_prd[j] = '0;
        end
        // Snapshot is taken right after the branch lane's own write.
        for (int i = 0; i < WIDTH; i++) begin
            if (ren[i]) spec_next[in_rd[i]] = lane_prd[i];
            if (in_valid[i] && in_is_branch[i]) begin
                snap         = spec_next;
                has_br       = 1'b1;
                lane_ckpt[i] = tail;
            end
        end
    end

    always_comb begin
        comm_next = comm_map;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit_en[i] && commit_arch_rd[i] != 5'd0)
                comm_next[commit_arch_rd[i]] = commit_phys_rd[i];
        end
    end

    assign empty    = (head == tail) && !full;
    assign head_rel = head + CW'(ckpt_release && !empty);
    assign full_eff = full && !ckpt_release;
    assign in_ready = reset_n && !flush_en && !recover_en
                      && (!(|out_valid) || out_ready)
                      && (fl_count >= (PW+1)'(n_ren))
                      && (!has_br || !full_eff);
    assign accept   = (|in_valid) && in_ready;
    assign fl_pop   = accept ? n_ren : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_map[a] <= PW'(a);
                comm_map[a] <= PW'(a);
                for (int c = 0; c < NUM_CKPT; c++) ckpt_mem[c][a] <= PW'(a);
            end
            head        <= '0;
            tail        <= '0;
            full        <= 1'b0;
            out_valid   <= '0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_old_prd <= '0;
            out_ckpt_id <= '0;
        end else begin
            comm_map <= comm_next;
            head     <= head_rel;
            if (ckpt_release && !empty) full <= 1'b0;
            if (flush_en) begin
                spec_map  <= comm_next;
                head      <= tail;
                full      <= 1'b0;
                out_valid <= '0;
            end else if (recover_en) begin
                // Restoring slot recover_id also releases it and every younger slot.
                spec_map  <= ckpt_mem[recover_id];
                tail      <= recover_id;
                full      <= 1'b0;
                out_valid <= '0;
            end else if (accept) begin
                spec_map    <= spec_next;
                out_valid   <= in_valid;
                out_prs1    <= prs1;
                out_prs2    <= prs2;
                out_prd     <= lane_prd;
                out_old_prd <= old_prd;
                out_ckpt_id <= lane_ckpt;
                if (has_br) begin
                    ckpt_mem[tail] <= snap;
                    tail           <= tail + CW'(1);
                    full           <= ((tail + CW'(1)) == head_rel);
                end
            end else if (out_ready) begin
                out_valid <= '0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(ckpt_release && empty))
                else $error("ckpt_release with empty checkpoint queue");
            assert ($countones(in_valid & in_is_branch) <= 1)
                else $error("more than one branch lane in a rename group");
        end
    end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt: bypass, allocation, checkpoint queue, recover and flush.
module tb_rename_map_ckpt;

    logic            clk, reset_n;
    logic [3:0]      in_valid, in_rd_valid, in_is_branch;
    logic [3:0][4:0] in_rs1, in_rs2, in_rd;
    logic            in_ready;
    logic [3:0][5:0] fl_phys;
    logic [6:0]      fl_count;
    logic [2:0]      fl_pop;
    logic [3:0]      out_valid;
    logic            out_ready;
    logic [3:0][5:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic [3:0][1:0] out_ckpt_id;
    logic [3:0]      commit_en;
    logic [3:0][4:0] commit_arch_rd;
    logic [3:0][5:0] commit_phys_rd;
    logic            ckpt_release, recover_en, flush_en;
    logic [1:0]      recover_id;

    int n_checks = 0;
    int n_fail   = 0;

    rename_map_ckpt dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_valid(in_rd_valid), .in_is_branch(in_is_branch), .in_ready(in_ready),
        .fl_phys(fl_phys), .fl_count(fl_count), .fl_pop(fl_pop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_old_prd(out_old_prd), .out_ckpt_id(out_ckpt_id),
        .commit_en(commit_en), .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd),
        .ckpt_release(ckpt_release), .recover_en(recover_en), .recover_id(recover_id),
        .flush_en(flush_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = '0; in_rd_valid = '0; in_is_branch = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        commit_en = '0; commit_arch_rd = '0; commit_phys_rd = '0;
        ckpt_release = 1'b0; recover_en = 1'b0; recover_id = '0; flush_en = 1'b0;
    endtask

    task automatic lane(input int l, input int rd, input int rdv, input int rs1, input int rs2, input int br);
        in_valid[l]     = 1'b1;
        in_rd[l]        = 5'(rd);
        in_rd_valid[l]  = 1'(rdv);
        in_rs1[l]       = 5'(rs1);
        in_rs2[l]       = 5'(rs2);
        in_is_branch[l] = 1'(br);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0; out_ready = 1'b1; fl_count = 7'd64; fl_phys = '0;
        clr();
        lane(0, 1, 1, 2, 3, 0);
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_fl_pop", 32'(fl_pop), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_prd", 32'(out_prd[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clr();

        // group r1 = r2 + r3, r4 = r1 + r1
        lane(0, 1, 1, 2, 3, 0); lane(1, 4, 1, 1, 1, 0);
        fl_phys[0] = 6'd32; fl_phys[1] = 6'd33;
        #1;
        chk("t1_in_ready", 32'(in_ready), 1);
        chk("t1_fl_pop", 32'(fl_pop), 2);
        tick(); clr();
        chk("t1_out_valid", 32'(out_valid), 3);
        chk("t1_prd0", 32'(out_prd[0]), 32);
        chk("t1_prd1", 32'(out_prd[1]), 33);
        chk("t1_prs1_0", 32'(out_prs1[0]), 2);
        chk("t1_prs1_1", 32'(out_prs1[1]), 32);
        chk("t1_prs2_1", 32'(out_prs2[1]), 32);
        chk("t1_old0", 32'(out_old_prd[0]), 1);
        chk("t1_old1", 32'(out_old_prd[1]), 4);

        // WAW on r5 across lanes 0 and 2; lane 3 reads r5 without renaming
        lane(0, 5, 1, 0, 0, 0); lane(1, 6, 1, 5, 0, 0); lane(2, 5, 1, 5, 6, 0); lane(3, 7, 0, 5, 1, 0);
        fl_phys[0] = 6'd40; fl_phys[1] = 6'd41; fl_phys[2] = 6'd42; fl_phys[3] = 6'd43;
        #1;
        chk("t2_fl_pop", 32'(fl_pop), 3);
        tick(); clr();
        chk("t2_out_valid", 32'(out_valid), 15);
        chk("t2_prd2", 32'(out_prd[2]), 42);
        chk("t2_prd3", 32'(out_prd[3]), 0);
        chk("t2_prs1_1", 32'(out_prs1[1]), 40);
        chk("t2_prs2_2", 32'(out_prs2[2]), 41);
        chk("t2_old2", 32'(out_old_prd[2]), 40);
        chk("t2_prs1_3", 32'(out_prs1[3]), 42);
        chk("t2_prs2_3", 32'(out_prs2[3]), 32);

        // map now holds r5 -> 42
        lane(0, 0, 0, 5, 4, 0);
        #1;
        chk("t2m_fl_pop", 32'(fl_pop), 0);
        tick(); clr();
        chk("t2m_prs1", 32'(out_prs1[0]), 42);
        chk("t2m_prs2", 32'(out_prs2[0]), 33);

        // output backpressure holds the registered group
        out_ready = 1'b0;
        lane(0, 8, 1, 0, 0, 0);
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_fl_pop", 32'(fl_pop), 0);
        tick(); clr();
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_prs1_hold", 32'(out_prs1[0]), 42);

        // too few free regs
        out_ready = 1'b1; fl_count = 7'd1;
        lane(0, 8, 1, 0, 0, 0); lane(1, 9, 1, 0, 0, 0);
        #1;
        chk("t3_in_ready", 32'(in_ready), 0);
        chk("t3_fl_pop", 32'(fl_pop), 0);
        tick(); clr();
        chk("t3_out_valid", 32'(out_valid), 0);
        chk("t3_prs1_hold", 32'(out_prs1[0]), 42);

        // branch takes ckpt 0, then r7 -> 50 with exactly one free reg
        fl_count = 7'd64;
        lane(0, 0, 0, 0, 0, 1);
        tick(); clr();
        chk("t4_br_valid", 32'(out_valid), 1);
        chk("t4_br_id", 32'(out_ckpt_id[0]), 0);
        fl_count = 7'd1; fl_phys[0] = 6'd50;
        lane(0, 7, 1, 0, 0, 0);
        #1;
        chk("t4_exact_ready", 32'(in_ready), 1);
        tick(); clr();
        chk("t4_prd", 32'(out_prd[0]), 50);
        chk("t4_old", 32'(out_old_prd[0]), 7);
        fl_count = 7'd64;
        recover_en = 1'b1; recover_id = 2'd0;
        lane(0, 8, 1, 0, 0, 0);
        #1;
        chk("t4_rec_ready", 32'(in_ready), 0);
        tick(); clr();
        chk("t4_rec_valid", 32'(out_valid), 0);
        lane(0, 0, 0, 7, 5, 0); lane(1, 0, 0, 0, 0, 1);
        tick(); clr();
        chk("t4_r7_restored", 32'(out_prs1[0]), 7);
        chk("t4_r5_kept", 32'(out_prs2[0]), 42);
        chk("t4_tail_zero", 32'(out_ckpt_id[1]), 0);

        // fill the checkpoint queue
        for (int i = 1; i < 4; i++) begin
            lane(0, 0, 0, 0, 0, 1);
            tick(); clr();
            chk("t5_fill_id", 32'(out_ckpt_id[0]), 32'(i));
        end
        lane(0, 12, 1, 0, 0, 1);
        #1;
        chk("t5_full_ready", 32'(in_ready), 0);
        chk("t5_full_pop", 32'(fl_pop), 0);
        clr();
        fl_phys[0] = 6'd22;
        lane(0, 12, 1, 0, 0, 0);
        #1;
        chk("t5_nobr_ready", 32'(in_ready), 1);
        tick(); clr();
        chk("t5_nobr_prd", 32'(out_prd[0]), 22);
        ckpt_release = 1'b1;
        tick(); clr();
        lane(0, 0, 0, 0, 0, 0); lane(2, 0, 0, 0, 0, 1);
        #1;
        chk("t5_rel_ready", 32'(in_ready), 1);
        tick(); clr();
        chk("t5_wrap_id", 32'(out_ckpt_id[2]), 0);

        // speculative r9 -> 60, then flush with commits bypassed into the map
        fl_phys[0] = 6'd60;
        lane(0, 9, 1, 0, 0, 0);
        tick(); clr();
        chk("t6_spec_prd", 32'(out_prd[0]), 60);
        chk("t6_spec_old", 32'(out_old_prd[0]), 9);
        flush_en = 1'b1;
        commit_en = 4'b0111;
        commit_arch_rd[0] = 5'd9;  commit_phys_rd[0] = 6'd45;
        commit_arch_rd[1] = 5'd10; commit_phys_rd[1] = 6'd46;
        commit_arch_rd[2] = 5'd10; commit_phys_rd[2] = 6'd47;
        lane(0, 8, 1, 0, 0, 0);
        #1;
        chk("t6_flush_ready", 32'(in_ready), 0);
        tick(); clr();
        chk("t6_flush_valid", 32'(out_valid), 0);
        lane(0, 0, 0, 9, 10, 0); lane(1, 0, 0, 1, 5, 0); lane(2, 0, 0, 0, 0, 1);
        #1;
        chk("t6_post_ready", 32'(in_ready), 1);
        tick(); clr();
        chk("t6_r9", 32'(out_prs1[0]), 45);
        chk("t6_r10_dup", 32'(out_prs2[0]), 47);
        chk("t6_r1", 32'(out_prs1[1]), 1);
        chk("t6_r5", 32'(out_prs2[1]), 5);
        chk("t6_ckpt_id", 32'(out_ckpt_id[2]), 1);

        // rd 0 is never renamed and consumes no free-list entry
        fl_phys[0] = 6'd20; fl_phys[1] = 6'd21;
        lane(0, 0, 1, 0, 0, 0); lane(1, 13, 1, 0, 0, 0);
        #1;
        chk("rd0_fl_pop", 32'(fl_pop), 1);
        tick(); clr();
        chk("rd0_prd0", 32'(out_prd[0]), 0);
        chk("rd0_prd1", 32'(out_prd[1]), 20);
        chk("rd0_old1", 32'(out_old_prd[1]), 13);

        // asynchronous reset mid-operation
        lane(0, 14, 1, 0, 0, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_prd", 32'(out_prd[1]), 0);
        chk("mrst_in_ready", 32'(in_ready), 0);
        clr();
        @(negedge clk);
        reset_n = 1'b1;
        lane(0, 0, 0, 9, 13, 0);
        tick(); clr();
        chk("mrst_r9", 32'(out_prs1[0]), 9);
        chk("mrst_r13", 32'(out_prs2[0]), 13);
        chk("mrst_valid", 32'(out_valid), 1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
